mul_unit: RTL and testbench

RV32M arithmetic block for the RISC-V processor's execute stage. It computes the eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) on two 32-bit operands. The operation is selected by the instruction's funct3 field. The result is registered, with one-cycle latency.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_divider.sv | 48 ++++
 rtl/mul_unit.sv | 70 +++++++
 tb/tb_mul_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants for the RV32M arithmetic block: operand width and funct3 operation codes.
// Also carries the conditional-negate helper used by the signed divide path.
package mul_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] SEL_MUL    = 3'b000;
    localparam logic [2:0] SEL_MULH   = 3'b001;
    localparam logic [2:0] SEL_MULHSU = 3'b010;
    localparam logic [2:0] SEL_MULHU  = 3'b011;
    localparam logic [2:0] SEL_DIV    = 3'b100;
    localparam logic [2:0] SEL_DIVU   = 3'b101;
    localparam logic [2:0] SEL_REM    = 3'b110;
    localparam logic [2:0] SEL_REMU   = 3'b111;

    function automatic logic [XLEN-1:0] cond_negate(input logic neg, input logic [XLEN-1:0] val);
        return neg ? (~val + 1'b1) : val;
    endfunction

endpackage

// File: rtl/mul_divider.sv
// Combinational 32-bit signed/unsigned divider producing quotient and remainder.
// Divide-by-zero and signed-overflow results follow the RISC-V M-extension rules.
module mul_divider
    import mul_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_signed,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_uquot;
    logic [WIDTH-1:0] w_urem;
    logic             w_div_zero;
    logic             w_overflow;

    // Signed division runs on magnitudes; signs are restored afterwards.
    assign w_neg_a = i_signed & i_dividend[WIDTH-1];
    assign w_neg_b = i_signed & i_divisor[WIDTH-1];
    assign w_abs_a = cond_negate(w_neg_a, i_dividend);
    assign w_abs_b = cond_negate(w_neg_b, i_divisor);

    assign w_div_zero = (i_divisor == '0);
    assign w_overflow = i_signed && (i_dividend == SIGNED_MIN) && (i_divisor == '1);

    assign w_uquot = w_div_zero ? '1 : (w_abs_a / w_abs_b);
    assign w_urem  = w_div_zero ? '0 : (w_abs_a % w_abs_b);

    always_comb begin
        o_quot = cond_negate(w_neg_a ^ w_neg_b, w_uquot);
        o_rem  = cond_negate(w_neg_a, w_urem);
        if (w_div_zero) begin
            o_quot = '1;
            o_rem  = i_dividend;
        end else if (w_overflow) begin
            o_quot = SIGNED_MIN;
            o_rem  = '0;
        end
    end

endmodule

// File: rtl/mul_unit.sv
// RV32M execute-stage arithmetic: all eight M-extension ops with a single registered result.
// Define MUL_DIV_EN to compile in the divider; otherwise SELECT 100-111 yield zero.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [WIDTH-1:0] RESULT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT
);

    logic                      w_a_signed;
    logic                      w_b_signed;
    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;
    logic        [WIDTH-1:0]   w_next;
    logic        [WIDTH-1:0]   r_result_p1;

    // MUL ignores signedness, so only the high-half ops pick signed extension.
    assign w_a_signed = (SELECT == SEL_MULH) || (SELECT == SEL_MULHSU);
    assign w_b_signed = (SELECT == SEL_MULH);
    assign w_a_ext    = {{WIDTH{w_a_signed & DATA1[WIDTH-1]}}, DATA1};
    assign w_b_ext    = {{WIDTH{w_b_signed & DATA2[WIDTH-1]}}, DATA2};
    assign w_prod     = w_a_ext * w_b_ext;

`ifdef MUL_DIV_EN
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    mul_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .i_dividend (DATA1),
        .i_divisor  (DATA2),
        .i_signed   (~SELECT[0]),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );
`endif

    always_comb begin
        w_next = '0;
        case (SELECT)
            SEL_MUL:                        w_next = w_prod[WIDTH-1:0];
            SEL_MULH, SEL_MULHSU, SEL_MULHU: w_next = w_prod[2*WIDTH-1:WIDTH];
`ifdef MUL_DIV_EN
            SEL_DIV, SEL_DIVU:              w_next = w_quot;
            SEL_REM, SEL_REMU:              w_next = w_rem;
`endif
            default:                        w_next = '0;
        endcase
    end

    // ---- stage p1: result register ----
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_result_p1 <= '0;
        end else begin
            r_result_p1 <= w_next;
        end
    end

    assign RESULT = r_result_p1;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus randomized ops against a
// 64-bit arithmetic reference model; follows MUL_DIV_EN the same way the design does.
module tb_mul_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] RESULT;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [2:0]  SELECT;

    int checks;
    int failures;

    mul_unit #(
        .WIDTH (32)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .RESULT (RESULT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .SELECT (SELECT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] s);
        longint          sa;
        longint          sb;
        longint          ub;
        longint unsigned up;
        longint          p;
        int              ia;
        int              ib;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        r  = 32'd0;
        case (s)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
`ifdef MUL_DIV_EN
            3'd4: begin
                if (b == 32'd0)                                r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else                                           r = ia / ib;
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0)                                r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else                                           r = ia % ib;
            end
            3'd7: r = (b == 32'd0) ? a : a % b;
`endif
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (RESULT === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, RESULT, exp);
        end
    endtask

    // One operation per cycle: drive on the falling edge, check just after the next rising edge.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] s, input logic [31:0] exp);
        @(negedge CLK);
        DATA1  = a;
        DATA2  = b;
        SELECT = s;
        @(posedge CLK);
        #1;
        check(tag, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] sweep_exp [8];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rs;

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b1;
        DATA1    = 32'd5;
        DATA2    = 32'd7;
        SELECT   = 3'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_init", 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        sweep_exp[0] = 32'd3;
        sweep_exp[1] = 32'd0;
        sweep_exp[2] = 32'd0;
        sweep_exp[3] = 32'd0;
`ifdef MUL_DIV_EN
        sweep_exp[4] = 32'd3;
        sweep_exp[5] = 32'd3;
`else
        sweep_exp[4] = 32'd0;
        sweep_exp[5] = 32'd0;
`endif
        sweep_exp[6] = 32'd0;
        sweep_exp[7] = 32'd0;
        for (int i = 0; i < 8; i++)
            op($sformatf("sweep_sel%0d", i), 32'd3, 32'd1, 3'(i), sweep_exp[i]);

        op("mul_3_m1",      32'd3,          32'hFFFF_FFFF, 3'd0, 32'hFFFF_FFFD);
        op("mulh_1_m1",     32'd1,          32'hFFFF_FFFF, 3'd1, 32'hFFFF_FFFF);
        op("mulhsu_1_m1",   32'd1,          32'hFFFF_FFFF, 3'd2, 32'h0000_0000);
        op("mulhu_m1_1",    32'hFFFF_FFFF,  32'd1,         3'd3, 32'h0000_0000);
        op("mulhu_3_fffe",  32'd3,          32'hFFFF_FFFE, 3'd3, 32'h0000_0002);
        op("mulhu_m1_m1",   32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'd3, 32'hFFFF_FFFE);
        op("mulhsu_m1_m1",  32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'd2, 32'hFFFF_FFFF);

`ifdef MUL_DIV_EN
        op("div_7_0",       32'd7,          32'd0,         3'd4, 32'hFFFF_FFFF);
        op("remu_7_0",      32'd7,          32'd0,         3'd7, 32'd7);
        op("divu_7_0",      32'd7,          32'd0,         3'd5, 32'hFFFF_FFFF);
        op("rem_7_0",       32'd7,          32'd0,         3'd6, 32'd7);
        op("div_ovf",       32'h8000_0000,  32'hFFFF_FFFF, 3'd4, 32'h8000_0000);
        op("rem_ovf",       32'h8000_0000,  32'hFFFF_FFFF, 3'd6, 32'd0);
        op("div_m7_2",      32'hFFFF_FFF9,  32'd2,         3'd4, 32'hFFFF_FFFD);
        op("rem_m7_2",      32'hFFFF_FFF9,  32'd2,         3'd6, 32'hFFFF_FFFF);
        op("div_6_3",       32'd6,          32'd3,         3'd4, 32'd2);
`else
        op("div_off_6_3",   32'd6,          32'd3,         3'd4, 32'd0);
        op("rem_off_7_0",   32'd7,          32'd0,         3'd6, 32'd0);
        op("remu_off_7_2",  32'd7,          32'd2,         3'd7, 32'd0);
`endif
        op("mul_6_3",       32'd6,          32'd3,         3'd0, 32'd18);

        // Reset wins over a nonzero operation sampled at the same edge.
        @(negedge CLK);
        RESET  = 1'b1;
        DATA1  = 32'd6;
        DATA2  = 32'd3;
        SELECT = 3'd0;
        @(posedge CLK);
        #1;
        check("reset_mid", 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        op("post_reset",    32'd9,          32'd5,         3'd0, 32'd45);
        op("b2b_1",         32'h0001_0000,  32'h0001_0000, 3'd3, 32'd1);
        op("b2b_2",         32'd2,          32'hFFFF_FFFF, 3'd1, 32'hFFFF_FFFF);

        for (int n = 0; n < 300; n++) begin
            ra = pick();
            rb = pick();
            rs = 3'($urandom_range(0, 7));
            op($sformatf("rand%0d_sel%0d_%h_%h", n, rs, ra, rb), ra, rb, rs, ref_op(ra, rb, rs));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
